// File: rtl/hazard_unit_mc.sv
// Hazard controller for the five-stage RISC-V pipeline. It handles M/W forwarding,
// load-use/RAW stalls, branch flushes, a multi-cycle execute sequencer and a stall counter.
module hazard_unit_mc #(
    parameter int REG_W   = 5,
    parameter int FWD_EN  = 1,
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs1_d,
    input  logic [REG_W-1:0] rs2_d,
    input  logic [REG_W-1:0] rs1_e,
    input  logic [REG_W-1:0] rs2_e,
    input  logic [REG_W-1:0] rd_e,
    input  logic [REG_W-1:0] rd_m,
    input  logic [REG_W-1:0] rd_w,
    input  logic             reg_write_e,
    input  logic             reg_write_m,
    input  logic             reg_write_w,
    input  logic             load_e,
    input  logic             pc_src_e,
    input  logic             mul_start_e,
    input  logic             cnt_clr,
    output logic [1:0]       forward_ae,
    output logic [1:0]       forward_be,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_m,
    output logic             mul_busy,
    output logic             mul_done,
    output logic [CNT_W-1:0] stall_cnt
);

    // Wide enough to hold MUL_LAT-2, the first value loaded into the down-counter.
    localparam int SEQ_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nxt;
    logic [SEQ_W-1:0] cnt, cnt_nxt;
    logic             mul_stall;
    logic             src_hit_e, src_hit_m, data_stall;

    // x0 is hard-wired to zero, so it never creates a dependency.
    function automatic logic reg_hit(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    // NOTE: every output of a combinational block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        forward_ae = 2'b00;
        forward_be = 2'b00;
        if (FWD_EN != 0) begin
            if (reg_write_m && reg_hit(rs1_e, rd_m))      forward_ae = 2'b10;
            else if (reg_write_w && reg_hit(rs1_e, rd_w)) forward_ae = 2'b01;
            if (reg_write_m && reg_hit(rs2_e, rd_m))      forward_be = 2'b10;
            else if (reg_write_w && reg_hit(rs2_e, rd_w)) forward_be = 2'b01;
        end
    end

    assign src_hit_e = reg_write_e && (reg_hit(rs1_d, rd_e) || reg_hit(rs2_d, rd_e));
    assign src_hit_m = reg_write_m && (reg_hit(rs1_d, rd_m) || reg_hit(rs2_d, rd_m));
    // Without forwarding every pending E/M write stalls D; W is covered by the write-first regfile.
    assign data_stall = (FWD_EN != 0) ? (load_e && src_hit_e) : (src_hit_e || src_hit_m);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mul_stall = 1'b0;
        case (state)
            IDLE: begin
                if (mul_start_e && !pc_src_e) begin
                    mul_stall = 1'b1;
                    state_nxt = BUSY;
                    cnt_nxt   = SEQ_W'(MUL_LAT - 2);
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    mul_stall = 1'b1;
                    cnt_nxt   = cnt - SEQ_W'(1);
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        flush_m  = 1'b0;
        mul_busy = 1'b0;
        mul_done = 1'b0;
        if (reset) begin
            stall_f  = !pc_src_e && (data_stall || mul_stall);
            stall_d  = !pc_src_e && (data_stall || mul_stall);
            stall_e  = mul_stall;
            flush_m  = mul_stall;
            flush_d  = pc_src_e;
            // While E is held by the sequencer a load-use bubble would destroy the op in E.
            flush_e  = pc_src_e || (data_stall && !mul_stall);
            mul_busy = (state == BUSY);
            mul_done = (state == BUSY) && (cnt == '0);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (stall_d && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench for hazard_unit_mc: a forwarding instance (MUL_LAT=4, CNT_W=4) and a
// no-forwarding instance (MUL_LAT=3, CNT_W=16) share stimulus and are compared to a reference model.
module tb_hazard_unit_mc;

    localparam int LAT_A = 4;
    localparam int LAT_B = 3;
    localparam int MAX_A = 15;
    localparam int MAX_B = 65535;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       reg_write_e, reg_write_m, reg_write_w, load_e, pc_src_e, mul_start_e, cnt_clr;

    logic [1:0]  fae_a, fbe_a, fae_b, fbe_b;
    logic        sf_a, sd_a, se_a, fd_a, fe_a, fm_a, busy_a, done_a;
    logic        sf_b, sd_b, se_b, fd_b, fe_b, fm_b, busy_b, done_b;
    logic [3:0]  cnt_a_o;
    logic [15:0] cnt_b_o;

    typedef struct packed {
        logic [15:0] cnt;
        logic [1:0]  fae;
        logic [1:0]  fbe;
        logic        sf, sd, se, fd, fe, fm, busy, done;
    } obs_t;

    int total = 0;
    int bad   = 0;
    // Reference state: position of the running op in its MUL_LAT-cycle life (0 = none), stall count.
    int age_a = 0, age_b = 0, mcnt_a = 0, mcnt_b = 0;

    always #5 clk = ~clk;

    hazard_unit_mc #(.REG_W(5), .FWD_EN(1), .MUL_LAT(LAT_A), .CNT_W(4)) dut_a (
        .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .reg_write_e(reg_write_e), .reg_write_m(reg_write_m),
        .reg_write_w(reg_write_w), .load_e(load_e), .pc_src_e(pc_src_e), .mul_start_e(mul_start_e),
        .cnt_clr(cnt_clr), .forward_ae(fae_a), .forward_be(fbe_a), .stall_f(sf_a), .stall_d(sd_a),
        .stall_e(se_a), .flush_d(fd_a), .flush_e(fe_a), .flush_m(fm_a), .mul_busy(busy_a),
        .mul_done(done_a), .stall_cnt(cnt_a_o)
    );

    hazard_unit_mc #(.REG_W(5), .FWD_EN(0), .MUL_LAT(LAT_B), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .reg_write_e(reg_write_e), .reg_write_m(reg_write_m),
        .reg_write_w(reg_write_w), .load_e(load_e), .pc_src_e(pc_src_e), .mul_start_e(mul_start_e),
        .cnt_clr(cnt_clr), .forward_ae(fae_b), .forward_be(fbe_b), .stall_f(sf_b), .stall_d(sd_b),
        .stall_e(se_b), .flush_d(fd_b), .flush_e(fe_b), .flush_m(fm_b), .mul_busy(busy_b),
        .mul_done(done_b), .stall_cnt(cnt_b_o)
    );

    function automatic obs_t act_a();
        obs_t o;
        o = {16'(cnt_a_o), fae_a, fbe_a, sf_a, sd_a, se_a, fd_a, fe_a, fm_a, busy_a, done_a};
        return o;
    endfunction

    function automatic obs_t act_b();
        obs_t o;
        o = {cnt_b_o, fae_b, fbe_b, sf_b, sd_b, se_b, fd_b, fe_b, fm_b, busy_b, done_b};
        return o;
    endfunction

    function automatic bit same(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    // Which cycle of a multi-cycle op E is in right now (1..LAT), or 0 if none.
    function automatic int model_eff(input int age);
        if (age != 0) return age;
        return (mul_start_e && !pc_src_e) ? 1 : 0;
    endfunction

    function automatic obs_t model_out(input bit fwd, input int lat, input int age, input int cnt);
        obs_t o;
        bit   he, hm, haz, ms, br;
        int   eff;
        o  = '0;
        br = pc_src_e;
        if (fwd) begin
            if (reg_write_m && same(rs1_e, rd_m))      o.fae = 2'b10;
            else if (reg_write_w && same(rs1_e, rd_w)) o.fae = 2'b01;
            if (reg_write_m && same(rs2_e, rd_m))      o.fbe = 2'b10;
            else if (reg_write_w && same(rs2_e, rd_w)) o.fbe = 2'b01;
        end
        he  = reg_write_e && (same(rs1_d, rd_e) || same(rs2_d, rd_e));
        hm  = reg_write_m && (same(rs1_d, rd_m) || same(rs2_d, rd_m));
        haz = fwd ? (load_e && he) : (he || hm);
        eff = model_eff(age);
        ms  = (eff != 0) && (eff < lat);
        if (reset) begin
            o.sf   = !br && (haz || ms);
            o.sd   = o.sf;
            o.se   = ms;
            o.fm   = ms;
            o.fd   = br;
            o.fe   = br || (haz && !ms);
            o.busy = (eff >= 2);
            o.done = (eff == lat);
        end
        o.cnt = 16'(cnt);
        return o;
    endfunction

    function automatic void model_reset();
        age_a = 0; age_b = 0; mcnt_a = 0; mcnt_b = 0;
    endfunction

    // Advances one clock edge and the reference model with it; returns 1 time unit after the edge.
    task automatic step();
        obs_t oa, ob;
        int   ea, eb;
        bit   rst_now, clr_now;
        ea = model_eff(age_a);
        eb = model_eff(age_b);
        oa = model_out(1'b1, LAT_A, age_a, mcnt_a);
        ob = model_out(1'b0, LAT_B, age_b, mcnt_b);
        rst_now = reset;
        clr_now = cnt_clr;
        @(posedge clk);
        #1;
        if (!rst_now) begin
            model_reset();
        end else begin
            age_a  = (ea == 0 || ea == LAT_A) ? 0 : ea + 1;
            age_b  = (eb == 0 || eb == LAT_B) ? 0 : eb + 1;
            mcnt_a = clr_now ? 0 : ((oa.sd && mcnt_a < MAX_A) ? mcnt_a + 1 : mcnt_a);
            mcnt_b = clr_now ? 0 : ((ob.sd && mcnt_b < MAX_B) ? mcnt_b + 1 : mcnt_b);
        end
    endtask

    task automatic idle_inputs();
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
        reg_write_e = 0; reg_write_m = 0; reg_write_w = 0;
        load_e = 0; pc_src_e = 0; mul_start_e = 0; cnt_clr = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        model_reset();
        mul_start_e = 1; load_e = 1; reg_write_e = 1; rd_e = 5'd7; rs2_d = 5'd7; pc_src_e = 1;
        #2;
        total++;
        if ({sf_a, sd_a, se_a, fd_a, fe_a, fm_a, busy_a, done_a} !== 8'h00) begin
            bad++; $display("FAIL reset_ctl_a got=%b want=00000000",
                            {sf_a, sd_a, se_a, fd_a, fe_a, fm_a, busy_a, done_a});
        end
        total++;
        if ({sf_b, sd_b, se_b, fd_b, fe_b, fm_b, busy_b, done_b} !== 8'h00) begin
            bad++; $display("FAIL reset_ctl_b got=%b want=00000000",
                            {sf_b, sd_b, se_b, fd_b, fe_b, fm_b, busy_b, done_b});
        end
        step();
        idle_inputs();
        reset = 1'b1;
        #1;
        total++;
        if (cnt_a_o !== 4'd0 || cnt_b_o !== 16'd0 || busy_a !== 1'b0) begin
            bad++; $display("FAIL reset_cnt got a=%0d b=%0d busy=%b want 0 0 0", cnt_a_o, cnt_b_o, busy_a);
        end
    endtask

    task automatic test_forward();
        idle_inputs();
        rd_m = 5'd5; rd_w = 5'd5; reg_write_m = 1; reg_write_w = 1; rs1_e = 5'd5;
        #1;
        total++;
        if (fae_a !== 2'b10 || fae_b !== 2'b00) begin
            bad++; $display("FAIL fwd_m_prio got a=%b b=%b want a=10 b=00", fae_a, fae_b);
        end
        reg_write_m = 0;
        #1;
        total++;
        if (fae_a !== 2'b01) begin
            bad++; $display("FAIL fwd_w got=%b want=01", fae_a);
        end
        reg_write_m = 1; rs1_e = 5'd0; rd_m = 5'd0; rd_w = 5'd0;
        #1;
        total++;
        if (fae_a !== 2'b00) begin
            bad++; $display("FAIL fwd_x0 got=%b want=00", fae_a);
        end
        rs2_e = 5'd9; rd_w = 5'd9; rd_m = 5'd4;
        #1;
        total++;
        if (fbe_a !== 2'b01 || fae_a !== 2'b00) begin
            bad++; $display("FAIL fwd_b got be=%b ae=%b want be=01 ae=00", fbe_a, fae_a);
        end
        idle_inputs();
        #1;
    endtask

    task automatic test_load_use();
        idle_inputs();
        load_e = 1; reg_write_e = 1; rd_e = 5'd7; rs2_d = 5'd7;
        #1;
        total++;
        if ({sf_a, sd_a, fe_a, fd_a, se_a} !== 5'b11100 || cnt_a_o !== 4'd0) begin
            bad++; $display("FAIL load_use got sf,sd,fe,fd,se=%b cnt=%0d want 11100 cnt=0",
                            {sf_a, sd_a, fe_a, fd_a, se_a}, cnt_a_o);
        end
        step();
        idle_inputs();
        #1;
        total++;
        if (cnt_a_o !== 4'd1 || sf_a !== 1'b0) begin
            bad++; $display("FAIL load_use_cnt got cnt=%0d sf=%b want cnt=1 sf=0", cnt_a_o, sf_a);
        end
        load_e = 1; reg_write_e = 1; rd_e = 5'd7; rs2_d = 5'd7; pc_src_e = 1;
        #1;
        total++;
        if ({sf_a, sd_a, fd_a, fe_a} !== 4'b0011) begin
            bad++; $display("FAIL branch_over_lu got sf,sd,fd,fe=%b want 0011", {sf_a, sd_a, fd_a, fe_a});
        end
        step();
        idle_inputs();
        #1;
        total++;
        if (cnt_a_o !== 4'd1) begin
            bad++; $display("FAIL branch_cnt got=%0d want=1", cnt_a_o);
        end
    endtask

    task automatic test_mul();
        logic [5:0] exp_v;
        idle_inputs();
        mul_start_e = 1;
        for (int k = 1; k <= LAT_A; k++) begin
            #1;
            exp_v = {{4{k < LAT_A}}, (k >= 2), (k == LAT_A)};
            total++;
            if ({sf_a, sd_a, se_a, fm_a, busy_a, done_a} !== exp_v) begin
                bad++; $display("FAIL mul_cycle%0d got sf,sd,se,fm,busy,done=%b want %b",
                                k, {sf_a, sd_a, se_a, fm_a, busy_a, done_a}, exp_v);
            end
            step();
        end
        mul_start_e = 0;
        #1;
        total++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || cnt_a_o !== 4'd4) begin
            bad++; $display("FAIL mul_after got busy=%b done=%b cnt=%0d want 0 0 4", busy_a, done_a, cnt_a_o);
        end
        repeat (3) step();
    endtask

    task automatic test_nofwd();
        idle_inputs();
        rd_e = 5'd3; reg_write_e = 1; rs1_d = 5'd3; rs1_e = 5'd3; rd_m = 5'd3; reg_write_m = 1;
        #1;
        total++;
        if ({sf_b, sd_b, fe_b} !== 3'b111 || fae_b !== 2'b00 || fae_a !== 2'b10 || sf_a !== 1'b0) begin
            bad++; $display("FAIL nofwd_raw got b sf,sd,fe=%b fae_b=%b fae_a=%b sf_a=%b want 111 00 10 0",
                            {sf_b, sd_b, fe_b}, fae_b, fae_a, sf_a);
        end
        rd_e = 5'd0; rd_m = 5'd0; rd_w = 5'd3; reg_write_w = 1;
        #1;
        total++;
        if ({sf_b, sd_b, fe_b} !== 3'b000 || fae_a !== 2'b01) begin
            bad++; $display("FAIL nofwd_w got b sf,sd,fe=%b fae_a=%b want 000 01", {sf_b, sd_b, fe_b}, fae_a);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_busy();
        int stalls, dones;
        idle_inputs();
        mul_start_e = 1;
        #1;
        total++;
        if (sf_a !== 1'b1) begin
            bad++; $display("FAIL rb_cycle1 got sf=%b want 1", sf_a);
        end
        step();
        #1;
        total++;
        if (busy_a !== 1'b1 || se_a !== 1'b1) begin
            bad++; $display("FAIL rb_cycle2 got busy=%b se=%b want 1 1", busy_a, se_a);
        end
        #2;
        reset = 1'b0;
        model_reset();
        #2;
        total++;
        if ({sf_a, sd_a, se_a, fm_a, busy_a, done_a, sf_b, busy_b} !== 8'h00) begin
            bad++; $display("FAIL rb_abort got=%b want=00000000",
                            {sf_a, sd_a, se_a, fm_a, busy_a, done_a, sf_b, busy_b});
        end
        step();
        reset = 1'b1;
        mul_start_e = 0;
        dones = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (done_a || busy_a) dones++;
            step();
        end
        total++;
        if (dones != 0) begin
            bad++; $display("FAIL rb_no_done got busy/done cycles=%0d want 0", dones);
        end
        stalls = 0; dones = 0;
        for (int k = 0; k < LAT_A + 2; k++) begin
            mul_start_e = (k < LAT_A);
            #1;
            if (sf_a) stalls++;
            if (done_a) dones++;
            step();
        end
        mul_start_e = 0;
        total++;
        if (stalls != LAT_A - 1 || dones != 1) begin
            bad++; $display("FAIL rb_restart got stalls=%0d dones=%0d want %0d 1", stalls, dones, LAT_A - 1);
        end
        repeat (3) step();
    endtask

    task automatic test_saturate();
        idle_inputs();
        load_e = 1; reg_write_e = 1; rd_e = 5'd12; rs1_d = 5'd12;
        repeat (20) step();
        #1;
        total++;
        if (cnt_a_o !== 4'd15) begin
            bad++; $display("FAIL sat got=%0d want=15", cnt_a_o);
        end
        cnt_clr = 1;
        step();
        cnt_clr = 0;
        #1;
        total++;
        if (cnt_a_o !== 4'd0 || cnt_b_o !== 16'd0) begin
            bad++; $display("FAIL clr got a=%0d b=%0d want 0 0", cnt_a_o, cnt_b_o);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_random();
        obs_t ea, eb;
        for (int n = 0; n < 600; n++) begin
            rs1_d = 5'($urandom_range(0, 7)); rs2_d = 5'($urandom_range(0, 7));
            rs1_e = 5'($urandom_range(0, 7)); rs2_e = 5'($urandom_range(0, 7));
            rd_e  = 5'($urandom_range(0, 7)); rd_m  = 5'($urandom_range(0, 7));
            rd_w  = 5'($urandom_range(0, 7));
            reg_write_e = 1'($urandom_range(0, 1)); reg_write_m = 1'($urandom_range(0, 1));
            reg_write_w = 1'($urandom_range(0, 1));
            load_e      = ($urandom_range(0, 2) == 0);
            pc_src_e    = ($urandom_range(0, 7) == 0);
            mul_start_e = ($urandom_range(0, 3) == 0);
            cnt_clr     = ($urandom_range(0, 31) == 0);
            reset       = ($urandom_range(0, 59) != 0);
            if (!reset) model_reset();
            #1;
            ea = model_out(1'b1, LAT_A, age_a, mcnt_a);
            eb = model_out(1'b0, LAT_B, age_b, mcnt_b);
            total++;
            if (act_a() !== ea) begin
                bad++; $display("FAIL rand_a n=%0d got=%h want=%h", n, act_a(), ea);
            end
            total++;
            if (act_b() !== eb) begin
                bad++; $display("FAIL rand_b n=%0d got=%h want=%h", n, act_b(), eb);
            end
            step();
        end
        reset = 1'b1;
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        reset = 1'b0;
        test_reset();
        test_forward();
        test_load_use();
        test_mul();
        test_nofwd();
        test_reset_busy();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_unit_mc.md
# hazard_unit_mc

Parametrised hazard controller for the five-stage pipelined RISC-V core. It generalises plain M/W operand forwarding with three additions: load-use stalling, taken-branch flushing, and a selectable no-forwarding mode. It also adds a stall-and-bubble sequencer for a multi-cycle execute unit (multiplier) and a saturating stall-cycle performance counter. It sits beside the datapath and drives its forward-select muxes and the stall/flush enables of the F/D, D/E and E/M pipeline registers.

## Interface
- REG_W, 5, register-index width
- FWD_EN, 1, 1 = forwarding from M/W; 0 = no forwarding, RAW hazards resolved by stalling
- MUL_LAT, 3, cycles a multi-cycle op occupies E; legal range 2..16
- CNT_W, 16, stall-counter width

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- rs1_d, rs2_d  in  REG_W  source registers of the instruction in D
- rs1_e, rs2_e, rd_e  in  REG_W  sources/destination of the instruction in E
- rd_m, rd_w  in  REG_W  destinations in M, W
- reg_write_e, reg_write_m, reg_write_w  in  1  destination valid per stage
- load_e  in  1  the instruction in E is a load
- pc_src_e  in  1  taken branch/jump resolved in E
- mul_start_e  in  1  the instruction in E is a multi-cycle op
- cnt_clr  in  1  synchronous clear of stall_cnt
- forward_ae, forward_be  out  2  00 regfile, 10 from M, 01 from W
- stall_f, stall_d, stall_e  out  1  hold PC, F/D, D/E registers
- flush_d, flush_e, flush_m  out  1  bubble into F/D, D/E, E/M registers
- mul_busy  out  1  sequencer is in BUSY
- mul_done  out  1  one-cycle pulse in the op's final E cycle
- stall_cnt  out  CNT_W  cycles with stall_d=1, saturating

## Operation
- Register x0 never matches: any comparison against index 0 is false.
- Forwarding (FWD_EN=1), per operand A/B: 10 if rsX_e==rd_m && reg_write_m; otherwise 01 if rsX_e==rd_w && reg_write_w; otherwise 00. M has priority over W.
- FWD_EN=0: forward_ae/be are constant 00.
  - RAW stall when rs1_d or rs2_d matches rd_e (with reg_write_e) or rd_m (with reg_write_m).
  - The register file is write-first, so a W match needs no action.
- Load-use (FWD_EN=1): load_e && reg_write_e && rd_e matches rs1_d or rs2_d.
- A load-use or RAW stall asserts stall_f=stall_d=flush_e=1.
- Branch: pc_src_e=1 asserts flush_d=flush_e=1 and forces stall_f=stall_d=0. The branch overrides any load-use or RAW stall in the same cycle.
- Multi-cycle FSM, states IDLE and BUSY, with a down-counter cnt:
  - IDLE & mul_start_e & !pc_src_e: assert stall_f, stall_d, stall_e, flush_m. Next state is BUSY with cnt=MUL_LAT-2.
  - BUSY & cnt!=0: assert the same four outputs; cnt decrements.
  - BUSY & cnt==0: no multi-cycle stall; mul_done=1; next state is IDLE. mul_start_e is ignored while BUSY.
  - Result: exactly MUL_LAT-1 stalled cycles, and the op leaves E on the MUL_LAT-th cycle.
- Multi-cycle stall ORs with load-use/RAW stall. flush_e from load-use is suppressed while stall_e=1, so E holds rather than bubbles.
- Forward selects are computed every cycle, including stalled cycles.
- mul_start_e together with pc_src_e is an illegal encoding. pc_src_e wins and the FSM stays IDLE.
- stall_cnt increments when stall_d=1 and stall_cnt is not all-ones. cnt_clr takes priority and loads 0.

## Timing
- reset low: FSM goes to IDLE, cnt=0, stall_cnt=0 immediately (asynchronous). All stall/flush/mul_* outputs are forced 0 while reset is low, regardless of inputs.
- A reset in the middle of BUSY aborts the op; no mul_done is generated.
- Forward, stall and flush outputs are combinational from inputs and state, valid in the same cycle. The datapath samples them at the next rising edge.
- mul_busy and mul_done are state-derived. mul_done is high in exactly one cycle per op.
- stall_cnt updates on the rising edge after the stalled cycle.

## Test plan
- FWD_EN=1, rd_m=rd_w=5 both writing, rs1_e=5 -> forward_ae=10. Same with reg_write_m=0 -> 01. rs1_e=0 with rd_m=0 -> 00.
- load_e=1, rd_e=7, rs2_d=7 -> stall_f=stall_d=flush_e=1 for one cycle; stall_cnt goes 0→1. Repeat with pc_src_e=1 -> flush_d=flush_e=1, stall_f=stall_d=0.
- MUL_LAT=4, mul_start_e held high for 4 cycles -> stall_f/d/e=flush_m=1 in cycles 1-3, mul_done=1 in cycle 4, mul_busy high in cycles 2-4.
- FWD_EN=0, rd_e=3 writing, rs1_d=3 -> stall + flush_e with forward_ae=00. Match only on rd_w -> no stall.
- Reset pulsed during BUSY cycle 2 -> outputs 0 at once, FSM IDLE, no mul_done. A new mul_start_e after release gives the full MUL_LAT-1 stall.
- CNT_W=4, 20 consecutive stalled cycles -> stall_cnt saturates at 15. cnt_clr=1 -> 0 on the next edge.
